fmul_rr_arbiter: RTL

Round-robin arbiter and sequencer that shares one pipelined FMUL datapath (sign/exponent/mantissa single-precision multiplier with error/overflow flags) between N_REQ requesters. It accepts operand pairs over valid/ready and issues at most one operation per cycle into FMUL. It tags each operation with its requester ID through a delay line matched to FMUL latency, then returns the result to that requester with a one-hot response strobe. It sits between the compute clients and the FMUL instance, in place of the per-client operand/result flops.

---
 rtl/fmul_arb_pkg.sv | 27 ++
 rtl/rr_pick.sv | 39 +++
 rtl/fmul_rr_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fmul_arb_pkg.sv
// Shared definitions for the round-robin FMUL arbiter.
//   N_REQ_DEF / LAT_DEF / MAX_OUT_DEF : default parameter values
//   clog2                             : ceiling log2 for constant sizing
//   IDW, tag_t                        : requester-ID width and delay-line tag
package fmul_arb_pkg;

    localparam int unsigned N_REQ_DEF   = 4;
    localparam int unsigned LAT_DEF     = 3;
    localparam int unsigned MAX_OUT_DEF = 4;
    localparam int unsigned N_REQ_MAX   = 8;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 1;
        return r;
    endfunction

    // ID field sized for the largest supported requester count.
    localparam int unsigned IDW = clog2(N_REQ_MAX);

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority select.
//   i_elig  : per-requester eligible vector
//   i_ptr   : index with highest priority this cycle
//   o_grant : one-hot grant (all-zero when nothing eligible)
//   o_idx   : encoded grant index
//   o_any   : at least one requester eligible
module rr_pick
    import fmul_arb_pkg::*;
#(
    parameter int unsigned N = N_REQ_DEF
) (
    input  logic [N-1:0]   i_elig,
    input  logic [IDW-1:0] i_ptr,
    output logic [N-1:0]   o_grant,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    int             w_off;
    int             w_sum;

    always_comb begin
        // Rotate so that bit 0 is the requester at i_ptr.
        w_dbl = {i_elig, i_elig} >> i_ptr;
        w_rot = w_dbl[N-1:0];
        o_any = |w_rot;
        w_off = 0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = k;
        end
        w_sum = int'(i_ptr) + w_off;
        if (w_sum >= int'(N)) w_sum = w_sum - int'(N);
        o_idx   = IDW'(w_sum);
        o_grant = o_any ? (N'(1) << w_sum) : '0;
    end

endmodule

// File: rtl/fmul_rr_arbiter.sv
// Round-robin sharing of one pipelined FMUL among N_REQ requesters.
//   i_req_valid/i_req_a/i_req_b/o_req_ready : per-requester operand handshake
//   o_fmul_a/o_fmul_b                       : registered operands to the FMUL
//   i_fmul_y/i_fmul_error/i_fmul_overflow   : FMUL result, LAT cycles after operands
//   o_rsp_valid (one-hot), o_rsp_y, o_rsp_error, o_rsp_overflow : registered response
//   o_busy                                  : any operation in flight
module fmul_rr_arbiter
    import fmul_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = N_REQ_DEF,
    parameter int unsigned LAT     = LAT_DEF,
    parameter int unsigned MAX_OUT = MAX_OUT_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_REQ-1:0]      i_req_valid,
    input  logic [32*N_REQ-1:0]   i_req_a,
    input  logic [32*N_REQ-1:0]   i_req_b,
    output logic [N_REQ-1:0]      o_req_ready,
    output logic [31:0]           o_fmul_a,
    output logic [31:0]           o_fmul_b,
    input  logic [31:0]           i_fmul_y,
    input  logic                  i_fmul_error,
    input  logic                  i_fmul_overflow,
    output logic [N_REQ-1:0]      o_rsp_valid,
    output logic [31:0]           o_rsp_y,
    output logic                  o_rsp_error,
    output logic                  o_rsp_overflow,
    output logic                  o_busy
);

    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_grant;
    logic [N_REQ-1:0] w_ready;
    logic [IDW-1:0]   w_idx;
    logic             w_any;
    logic             w_accept;
    logic [31:0]      w_sel_a;
    logic [31:0]      w_sel_b;
    logic [LAT:0]     w_tag_valids;

    logic [IDW-1:0]   r_rr_ptr;
    logic [3:0]       r_out_cnt [N_REQ];
    tag_t             r_tag [LAT+1];
    logic [31:0]      r_fmul_a;
    logic [31:0]      r_fmul_b;
    logic [N_REQ-1:0] r_rsp_valid;
    logic [31:0]      r_rsp_y;
    logic             r_rsp_error;
    logic             r_rsp_overflow;

    // Eligibility uses the registered count, so a slot freed by a response is
    // only reusable from the following cycle.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            w_elig[i] = i_req_valid[i] && (r_out_cnt[i] < 4'(MAX_OUT));
        end
    end

    rr_pick #(
        .N (N_REQ)
    ) u_pick (
        .i_elig  (w_elig),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_ready  = i_rst ? '0 : w_grant;
    assign w_accept = w_any && !i_rst;
    assign w_sel_a  = i_req_a[32*w_idx +: 32];
    assign w_sel_b  = i_req_b[32*w_idx +: 32];

    always_comb begin
        w_tag_valids = '0;
        for (int s = 0; s <= int'(LAT); s++) begin
            w_tag_valids[s] = r_tag[s].valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr       <= '0;
            r_fmul_a       <= '0;
            r_fmul_b       <= '0;
            r_rsp_valid    <= '0;
            r_rsp_y        <= '0;
            r_rsp_error    <= 1'b0;
            r_rsp_overflow <= 1'b0;
            for (int s = 0; s <= int'(LAT); s++) r_tag[s] <= '0;
            for (int i = 0; i < int'(N_REQ); i++) r_out_cnt[i] <= '0;
        end else begin
            if (w_accept) begin
                r_fmul_a <= w_sel_a;
                r_fmul_b <= w_sel_b;
                r_rr_ptr <= (32'(w_idx) == N_REQ - 1) ? '0 : w_idx + 1'b1;
            end
            r_tag[0] <= '{valid: w_accept, id: w_idx};
            for (int s = 1; s <= int'(LAT); s++) r_tag[s] <= r_tag[s-1];

            // Last tag stage lines up with the FMUL output of its operation.
            if (r_tag[LAT].valid) begin
                r_rsp_valid    <= N_REQ'(1) << r_tag[LAT].id;
                r_rsp_y        <= i_fmul_y;
                r_rsp_error    <= i_fmul_error;
                r_rsp_overflow <= i_fmul_overflow;
            end else begin
                r_rsp_valid <= '0;
            end

            for (int i = 0; i < int'(N_REQ); i++) begin
                if (w_ready[i] && !r_rsp_valid[i]) begin
                    r_out_cnt[i] <= r_out_cnt[i] + 4'd1;
                end else if (!w_ready[i] && r_rsp_valid[i]) begin
                    r_out_cnt[i] <= r_out_cnt[i] - 4'd1;
                end
            end
        end
    end

    assign o_req_ready    = w_ready;
    assign o_fmul_a       = r_fmul_a;
    assign o_fmul_b       = r_fmul_b;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_y        = r_rsp_y;
    assign o_rsp_error    = r_rsp_error;
    assign o_rsp_overflow = r_rsp_overflow;
    assign o_busy         = (|w_tag_valids) || (|r_rsp_valid);

    for (genvar gi = 0; gi < int'(N_REQ); gi++) begin : g_cnt_chk
        a_cnt_hold : assert property (@(posedge i_clk) disable iff (i_rst)
            (w_ready[gi] && r_rsp_valid[gi]) |=> $stable(r_out_cnt[gi]));
        a_cnt_bound : assert property (@(posedge i_clk) disable iff (i_rst)
            r_out_cnt[gi] <= 4'(MAX_OUT));
    end

endmodule
